// File: rtl/uart_host_pkg.sv
// Shared definitions for the UART host controller: register map, LSR bits, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_host_pkg;

  // UART register-stack addresses (DLL aliases RBR/THR while DLAB is set)
  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL     = 3'd0;
  localparam logic [2:0] ADDR_DLM     = 3'd1;
  localparam logic [2:0] ADDR_FCR     = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;
  localparam logic [2:0] ADDR_SCR     = 3'd7;

  // LSR bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_BI   = 4;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  typedef enum logic [3:0] {
    UNCFG   = 4'd0,
    C_LCRD  = 4'd1,
    C_DLL   = 4'd2,
    C_DLM   = 4'd3,
    C_LCR   = 4'd4,
    C_FCR   = 4'd5,
    POLL    = 4'd6,
    TX_PUSH = 4'd7,
    RX_POP  = 4'd8,
    RX_CAP  = 4'd9,
    SETTLE  = 4'd10
  } state_t;

endpackage

// File: rtl/uart_host_cfg_seq.sv
// Five-step UART configuration write sequencer (DLAB set, DLL, DLM, LCR, FCR).
// Latency: one register write per cycle; done pulses the cycle after the FCR write.
// Backpressure: none; the register bus accepts a write every cycle.
module uart_host_cfg_seq
  import uart_host_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  state_t      i_state,
  input  logic [15:0] i_div,
  input  logic [6:0]  i_lcr,
  input  logic [7:0]  i_fcr,
  output logic        o_wr,
  output logic [2:0]  o_addr,
  output logic [7:0]  o_wdata,
  output state_t      o_next,
  output logic        o_done
);

  logic [15:0] r_div;
  logic [6:0]  r_lcr;
  logic [7:0]  r_fcr;
  logic        r_done;

  // Snapshot the configuration when a sequence is launched so mid-sequence input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_lcr <= '0;
      r_fcr <= '0;
    end else if (i_start) begin
      r_div <= i_div;
      r_lcr <= i_lcr;
      r_fcr <= i_fcr;
    end
  end

  // Done is a registered pulse following the final (FCR) write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (i_state == C_FCR);
  end

  assign o_done = r_done;

  // Per-step write decode and successor state
  always_comb begin
    o_wr    = 1'b0;
    o_addr  = 3'd0;
    o_wdata = 8'd0;
    o_next  = i_state;
    case (i_state)
      C_LCRD: begin
        o_wr    = 1'b1;
        o_addr  = ADDR_LCR;
        o_wdata = {1'b1, r_lcr};
        o_next  = C_DLL;
      end
      C_DLL: begin
        o_wr    = 1'b1;
        o_addr  = ADDR_DLL;
        o_wdata = r_div[7:0];
        o_next  = C_DLM;
      end
      C_DLM: begin
        o_wr    = 1'b1;
        o_addr  = ADDR_DLM;
        o_wdata = r_div[15:8];
        o_next  = C_LCR;
      end
      C_LCR: begin
        o_wr    = 1'b1;
        o_addr  = ADDR_LCR;
        o_wdata = {1'b0, r_lcr};
        o_next  = C_FCR;
      end
      C_FCR: begin
        o_wr    = 1'b1;
        o_addr  = ADDR_FCR;
        o_wdata = r_fcr;
        o_next  = SETTLE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uart_host_ctrl.sv
// UART host controller: configures the UART, polls LSR, round-robins the register port between TX push and RX pop.
// Latency: RX byte valid 3 cycles after the POLL that saw DR; TX bursts of up to TX_DEPTH bytes back-to-back.
// Backpressure: tx_ready only while pushing with credit; a held rx_valid blocks further RX pops.
module uart_host_ctrl
  import uart_host_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter bit AUTO_CFG = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [15:0] cfg_div,
  input  logic [6:0]  cfg_lcr,
  input  logic [7:0]  cfg_fcr,
  output logic        cfg_done,
  output logic        busy,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [3:0]  err_status,
  input  logic        err_clr,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [2:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata
);

  localparam int CW = $clog2(TX_DEPTH + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_credit;
  logic          r_last_rx;
  logic          r_cfg_pend;
  logic          r_settle;
  logic          r_rx_valid;
  logic [7:0]    r_rx_data;
  logic [3:0]    r_err;

  logic          w_cfg_go;
  logic          w_grant_rx;
  logic          w_grant_tx;
  logic          w_thre;
  logic          w_dr;
  logic          w_rx_elig;
  logic          w_tx_elig;
  logic          w_cfg_req;
  logic          w_push;
  logic          w_seq_wr;
  logic [2:0]    w_seq_addr;
  logic [7:0]    w_seq_wdata;
  state_t        w_seq_next;
  logic          w_seq_done;
  logic [1:0]    w_unused_lsr;

  // LSR is only meaningful while POLL drives the LSR address
  assign w_thre       = reg_rdata[LSR_THRE];
  assign w_dr         = reg_rdata[LSR_DR];
  assign w_unused_lsr = reg_rdata[7:6];
  assign w_rx_elig    = w_dr && !r_rx_valid;
  assign w_tx_elig    = tx_valid && ((r_credit != '0) || w_thre);
  assign w_cfg_req    = r_cfg_pend || cfg_start;
  assign w_push       = (r_state == TX_PUSH) && tx_valid && (r_credit != '0);

  uart_host_cfg_seq u_cfg_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_cfg_go),
    .i_state (r_state),
    .i_div   (cfg_div),
    .i_lcr   (cfg_lcr),
    .i_fcr   (cfg_fcr),
    .o_wr    (w_seq_wr),
    .o_addr  (w_seq_addr),
    .o_wdata (w_seq_wdata),
    .o_next  (w_seq_next),
    .o_done  (w_seq_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UNCFG;
    else        r_state <= w_state_nxt;
  end

  // Next-state, arbitration and register-bus strobes (strobes decode from state so reset kills them at once)
  always_comb begin
    w_state_nxt = r_state;
    reg_wr      = 1'b0;
    reg_rd      = 1'b0;
    reg_addr    = 3'd0;
    reg_wdata   = 8'd0;
    w_cfg_go    = 1'b0;
    w_grant_rx  = 1'b0;
    w_grant_tx  = 1'b0;
    case (r_state)
      UNCFG: begin
        if (AUTO_CFG || w_cfg_req) begin
          w_cfg_go    = 1'b1;
          w_state_nxt = C_LCRD;
        end
      end
      C_LCRD, C_DLL, C_DLM, C_LCR, C_FCR: begin
        reg_wr      = w_seq_wr;
        reg_addr    = w_seq_addr;
        reg_wdata   = w_seq_wdata;
        w_state_nxt = w_seq_next;
      end
      POLL: begin
        reg_rd   = 1'b1;
        reg_addr = ADDR_LSR;
        if (w_cfg_req) begin
          w_cfg_go    = 1'b1;
          w_state_nxt = C_LCRD;
        end else if (w_rx_elig && w_tx_elig) begin
          // Both sides want the port: alternate against the previous grant
          if (r_last_rx) w_grant_tx = 1'b1;
          else           w_grant_rx = 1'b1;
        end else if (w_rx_elig) begin
          w_grant_rx = 1'b1;
        end else if (w_tx_elig) begin
          w_grant_tx = 1'b1;
        end
        if (w_grant_rx) w_state_nxt = RX_POP;
        if (w_grant_tx) w_state_nxt = TX_PUSH;
      end
      TX_PUSH: begin
        reg_wr    = w_push;
        reg_addr  = ADDR_RBR_THR;
        reg_wdata = tx_data;
        if (!w_push || (r_credit == CW'(1))) w_state_nxt = SETTLE;
      end
      RX_POP: begin
        reg_rd      = 1'b1;
        reg_addr    = ADDR_RBR_THR;
        w_state_nxt = RX_CAP;
      end
      RX_CAP: begin
        reg_addr    = ADDR_RBR_THR;
        w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (r_settle) w_state_nxt = POLL;
      end
      default: w_state_nxt = UNCFG;
    endcase
  end

  // Two-cycle settle counter, re-armed whenever we are outside SETTLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_settle <= 1'b0;
    else if (r_state == SETTLE)  r_settle <= ~r_settle;
    else                         r_settle <= 1'b0;
  end

  // TX credit: cleared by configuration, refilled when THRE is seen, spent per push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_credit <= '0;
    else if (r_state == C_FCR)           r_credit <= '0;
    else if ((r_state == POLL) && w_thre) r_credit <= CW'(TX_DEPTH);
    else if (w_push)                     r_credit <= r_credit - CW'(1);
  end

  // Remember which side won the last grant for round-robin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_last_rx <= 1'b0;
    else if (w_grant_rx) r_last_rx <= 1'b1;
    else if (w_grant_tx) r_last_rx <= 1'b0;
  end

  // Hold a reconfiguration request that arrives while the port is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cfg_pend <= 1'b0;
    else if (w_cfg_go)  r_cfg_pend <= 1'b0;
    else if (cfg_start) r_cfg_pend <= 1'b1;
  end

  // RX output register: capture after the pop, release on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'd0;
    end else if (r_state == RX_CAP) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= reg_rdata;
    end else if (r_rx_valid && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  // Sticky line errors; a clear wins over an error seen in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_err <= 4'd0;
    else if (err_clr)          r_err <= 4'd0;
    else if (r_state == POLL)  r_err <= r_err | reg_rdata[LSR_BI:LSR_OE];
  end

  assign cfg_done   = w_seq_done;
  assign busy       = r_state inside {UNCFG, C_LCRD, C_DLL, C_DLM, C_LCR, C_FCR};
  assign tx_ready   = w_push;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign err_status = r_err;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: register-bus model, TX source, write/RX scoreboards.
// Latency: n/a.
// Backpressure: bench drives rx_ready per test phase.
module tb_uart_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic [15:0] cfg_div;
  logic [6:0]  cfg_lcr;
  logic [7:0]  cfg_fcr;
  logic        cfg_done;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [3:0]  err_status;
  logic        err_clr;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;

  logic [7:0]  lsr_val;
  logic [7:0]  rbr_val;

  always #5 clk = ~clk;

  uart_host_ctrl #(.TX_DEPTH(16), .AUTO_CFG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_div(cfg_div), .cfg_lcr(cfg_lcr), .cfg_fcr(cfg_fcr),
    .cfg_done(cfg_done), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_status(err_status), .err_clr(err_clr),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // UART register stack model: combinational read data by address
  assign reg_rdata = (reg_addr == 3'd5) ? lsr_val :
                     (reg_addr == 3'd0) ? rbr_val : 8'h00;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  int         runs[$];
  bit         grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int run_len  = 0;
  int last_poll_cyc = 0;
  int pop_poll_cyc  = 0;
  logic prev_tx_ready = 1'b0;
  logic prev_rx_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(b);
    exp_wr.push_back({3'd0, b});
  endtask

  task automatic push_cfg(input logic [15:0] d, input logic [6:0] l, input logic [7:0] f);
    exp_wr.push_back({3'd3, 1'b1, l});
    exp_wr.push_back({3'd0, d[7:0]});
    exp_wr.push_back({3'd1, d[15:8]});
    exp_wr.push_back({3'd3, 1'b0, l});
    exp_wr.push_back({3'd2, f});
  endtask

  // sel: 0 tx_ready, 1 TX source drained, 2 cfg_done, 3 reg_wr
  task automatic wait_cond(input int sel, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = tx_ready;
        1: ok = (tx_q.size() == 0);
        2: ok = cfg_done;
        default: ok = reg_wr;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: event not seen within %0d cycles, required to occur", name, budget);
    end
  endtask

  // TX source: present the queue head, pop after an accepted cycle
  initial begin
    bit acc;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = tx_valid && tx_ready;
      @(posedge clk);
      #2;
      if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() > 0);
      tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  // Monitor: scoreboard writes and RX bytes, record grants, bursts and RX latency
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_wr || reg_rd) check("strobe_excl", {31'd0, reg_wr & reg_rd}, 32'd0);
        if (reg_wr) begin
          if (exp_wr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected (cycle %0d)", reg_addr, reg_wdata, cyc);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", {29'd0, reg_addr}, {29'd0, w.addr});
            check("wr_data", {24'd0, reg_wdata}, {24'd0, w.data});
          end
        end
        if (tx_ready) check("tx_ready_is_thr_write", {28'd0, reg_wr, reg_addr}, {28'd0, 1'b1, 3'd0});
        if (reg_rd && reg_addr == 3'd5) last_poll_cyc = cyc;
        if (reg_rd && reg_addr == 3'd0) begin
          exp_rx.push_back(rbr_val);
          pop_poll_cyc = last_poll_cyc;
          grant_log.push_back(1'b1);
        end
        if (tx_ready && !prev_tx_ready) grant_log.push_back(1'b0);
        if (tx_ready) run_len++;
        else if (run_len > 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
        if (rx_valid && !prev_rx_valid) check("rx_latency", cyc - pop_poll_cyc, 32'd3);
        if (rx_valid && rx_ready) begin
          if (exp_rx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rx: got 0x%0h, none expected", rx_data);
          end else begin
            check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
          end
        end
        if (cfg_done) done_cnt++;
      end
      prev_tx_ready = tx_ready;
      prev_rx_valid = rx_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] wr_hist;
    logic [7:0] done_hist;
    logic [5:0] gvec;
    int         nreads;

    rst_n = 1'b0; cfg_start = 1'b0; cfg_div = 16'h0145; cfg_lcr = 7'h03; cfg_fcr = 8'h07;
    rx_ready = 1'b0; err_clr = 1'b0; lsr_val = 8'h00; rbr_val = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_err", {28'd0, err_status}, 32'd0);

    // Auto configuration: five consecutive writes, then one done pulse
    push_cfg(16'h0145, 7'h03, 8'h07);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      wr_hist[7-k]   = reg_wr;
      done_hist[7-k] = cfg_done;
    end
    check("cfg_wr_timing", {24'd0, wr_hist}, 32'h7C);
    check("cfg_done_timing", {24'd0, done_hist}, 32'h02);
    check("busy_after_cfg", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    check("cfg_writes_drained", exp_wr.size(), 32'd0);

    // TX credit: 20 bytes, only 16 until THRE is seen again
    tick();
    lsr_val = 8'h60;
    for (int i = 0; i < 20; i++) push_tx(8'h10 + 8'(i));
    wait_cond(0, 50, "tx_first_push");
    #1 lsr_val = 8'h00;
    repeat (40) tick();
    check("tx_burst_len", (runs.size() > 0) ? runs[0] : -1, 32'd16);
    check("tx_held_back", tx_q.size(), 32'd4);
    lsr_val = 8'h60;
    wait_cond(1, 100, "tx_rest_drain");
    repeat (3) tick();
    lsr_val = 8'h00;
    repeat (6) tick();
    check("tx_second_burst", (runs.size() > 1) ? runs[1] : -1, 32'd4);

    // RX/TX round-robin with DR and THRE both set
    grant_log.delete();
    rbr_val = 8'hA5; rx_ready = 1'b1; lsr_val = 8'h61;
    for (int i = 0; i < 40; i++) push_tx(8'h80 + 8'(i));
    wait_cond(1, 600, "rr_drain");
    #1 lsr_val = 8'h00;
    repeat (10) tick();
    gvec = 6'd0;
    for (int i = 0; i < 6; i++) gvec[5-i] = (grant_log.size() > i) ? grant_log[i] : 1'b0;
    check("grant_alternation", {26'd0, gvec}, 32'b101010);

    // rx_valid held blocks further RX pops
    grant_log.delete();
    rbr_val = 8'h3C; rx_ready = 1'b0; lsr_val = 8'h01;
    repeat (30) tick();
    nreads = 0;
    foreach (grant_log[i]) if (grant_log[i]) nreads++;
    check("rx_block_reads", nreads, 32'd1);
    check("rx_valid_held", {31'd0, rx_valid}, 32'd1);
    check("rx_data_held", {24'd0, rx_data}, 32'h3C);
    lsr_val = 8'h00;
    tick();
    rx_ready = 1'b1;
    repeat (2) tick();
    check("rx_valid_released", {31'd0, rx_valid}, 32'd0);

    // Sticky error collection and clear priority
    lsr_val = 8'h65;
    repeat (12) tick();
    lsr_val = 8'h00;
    repeat (10) tick();
    check("err_pe", {28'd0, err_status}, 32'b0010);
    repeat (5) tick();
    check("err_sticky", {28'd0, err_status}, 32'b0010);
    lsr_val = 8'h08; err_clr = 1'b1;
    tick();
    lsr_val = 8'h00; err_clr = 1'b0;
    @(negedge clk);
    check("err_clr_priority", {28'd0, err_status}, 32'd0);
    tick();
    lsr_val = 8'h12;
    tick();
    lsr_val = 8'h00;
    @(negedge clk);
    check("err_bi_oe", {28'd0, err_status}, 32'b1001);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", {28'd0, err_status}, 32'd0);

    // Reconfiguration requested mid-burst runs after the burst
    tick();
    cfg_div = 16'h1234; cfg_lcr = 7'h1B; cfg_fcr = 8'hC1;
    lsr_val = 8'h60;
    for (int i = 0; i < 10; i++) push_tx(8'h50 + 8'(i));
    push_cfg(16'h1234, 7'h1B, 8'hC1);
    wait_cond(0, 50, "burst2_start");
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_cond(2, 100, "recfg_done");
    check("recfg_busy_low", {31'd0, busy}, 32'd0);
    check("recfg_writes_drained", exp_wr.size(), 32'd0);
    check("burst_not_aborted", (runs.size() > 0) ? runs[runs.size()-1] : -1, 32'd10);
    lsr_val = 8'h00;
    repeat (5) tick();

    // Reset in the middle of a configuration sequence
    lsr_val = 8'h02;
    tick();
    lsr_val = 8'h00;
    exp_wr.push_back({3'd3, 1'b1, 7'h1B});
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_cond(3, 20, "seq_write");
    #2 rst_n = 1'b0;
    #1;
    check("midseq_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
    check("midseq_busy", {31'd0, busy}, 32'd1);
    check("midseq_err", {28'd0, err_status}, 32'd0);
    check("midseq_rx_data", {24'd0, rx_data}, 32'd0);
    push_cfg(16'h1234, 7'h1B, 8'hC1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_cond(2, 20, "post_reset_cfg");
    repeat (3) tick();
    check("final_writes_drained", exp_wr.size(), 32'd0);
    check("final_rx_drained", exp_rx.size(), 32'd0);
    check("cfg_done_count", done_cnt, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
